// File: rtl/bg_noise_estimator_pkg.sv
// Shared definitions for the background-noise estimator: lane geometry,
// FSM state encoding and lane bit-offset helpers.
package bg_noise_estimator_pkg;

    localparam int LANES    = 16;
    localparam int SAMPLE_W = 8;
    localparam int NOISE_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } bg_state_e;

    // Bit offset of lane i inside the packed sample word.
    function automatic int sample_lsb(input int i);
        return SAMPLE_W * i;
    endfunction

    // Bit offset of lane i inside the packed noise word.
    function automatic int noise_lsb(input int i);
        return NOISE_W * i;
    endfunction

endpackage

// File: rtl/bg_lane_accumulator.sv
// One signed lane accumulator. Sums sign-extended samples and presents the
// floor-divided mean (arithmetic shift) sign-extended to the noise width.
module bg_lane_accumulator
    import bg_noise_estimator_pkg::*;
#(
    parameter int LOG2_PERIODS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                add_en,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [NOISE_W-1:0]  result
);

    // Wide enough for 2^LOG2_PERIODS full-scale samples, so it never wraps.
    localparam int ACC_W = SAMPLE_W + LOG2_PERIODS;

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    sample_ext;
    logic signed [SAMPLE_W-1:0] mean;

    assign sample_ext = {{LOG2_PERIODS{sample[SAMPLE_W-1]}}, sample};

    // Clear has priority so a restart discards any beat on the same edge.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = acc_q + sample_ext;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // The mean of SAMPLE_W-bit samples always fits in SAMPLE_W bits.
    assign mean   = SAMPLE_W'(acc_q >>> LOG2_PERIODS);
    assign result = {{(NOISE_W - SAMPLE_W){mean[SAMPLE_W-1]}}, mean};

endmodule

// File: rtl/bg_noise_estimator.sv
// Background-noise estimator: averages 2^LOG2_PERIODS period beats across
// 16 lanes and publishes a complete 256-bit estimate atomically.
module bg_noise_estimator
    import bg_noise_estimator_pkg::*;
#(
    parameter int LOG2_PERIODS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic [255:0] bg_noise,
    output logic         bg_valid,
    output logic         bg_update,
    output logic         busy
);

    localparam int CNT_W = LOG2_PERIODS + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((1 << LOG2_PERIODS) - 1);

    bg_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [255:0]       bg_noise_q, bg_noise_d;
    logic               bg_valid_q, bg_valid_d;
    logic               bg_update_q, bg_update_d;

    logic               acc_clear;
    logic               acc_add;
    logic               publish;
    logic [255:0]       lane_word;

    // Lane datapath: one accumulator per lane, results packed into one word.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam int S_LSB = sample_lsb(gi);
        localparam int N_LSB = noise_lsb(gi);

        bg_lane_accumulator #(
            .LOG2_PERIODS(LOG2_PERIODS)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (acc_clear),
            .add_en (acc_add),
            .sample (in_data[S_LSB +: SAMPLE_W]),
            .result (lane_word[N_LSB +: NOISE_W])
        );
    end

    // Next-state and control: start always restarts into ACCUM and wins
    // over both a same-edge beat and a pending publish.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        publish   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_clear = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (start) begin
                    acc_clear = 1'b1;
                    cnt_d     = '0;
                end else if (in_valid) begin
                    acc_add = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_PUBLISH;
                    end
                end
            end
            ST_PUBLISH: begin
                if (start) begin
                    acc_clear = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_ACCUM;
                end else begin
                    publish = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register next values: the estimate word changes only on publish.
    always_comb begin
        bg_noise_d  = bg_noise_q;
        bg_valid_d  = bg_valid_q;
        bg_update_d = publish;
        if (publish) begin
            bg_noise_d = lane_word;
            bg_valid_d = 1'b1;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bg_noise_q  <= '0;
            bg_valid_q  <= 1'b0;
            bg_update_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bg_noise_q  <= bg_noise_d;
            bg_valid_q  <= bg_valid_d;
            bg_update_q <= bg_update_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign busy      = (state_q != ST_IDLE);
    assign bg_noise  = bg_noise_q;
    assign bg_valid  = bg_valid_q;
    assign bg_update = bg_update_q;

endmodule
